// File: rtl/xrv1_retire_ctrl.sv
// xrv1_retire_ctrl
//   In-order retirement controller for the xrv1 instruction queue. Tracks a
//   completion bit per itag, scans from the queue head to count how many
//   consecutive valid+done entries can retire this cycle (capped), and
//   sequences a pipeline drain (RUN -> DRAIN -> IDLE).
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   issue_vld_i/itag_i   allocation of an itag (clears its done bit)
//   wb_vld_i/wb_itag_i   per-port completions (set done bit if entry valid)
//   iqueue_vld_i         iqueue entry valid vector
//   retire_itag_i        iqueue head pointer
//   drain_req_i          level drain request
//   retire_cnt_o         entries retiring this cycle (to iqueue)
//   issue_hold_o         block new issue (state != RUN)
//   drained_o            state == IDLE
//   wb_err_o             sticky: completion to an invalid entry
//   perf_retired_o       retired-instruction counter
//
// Build option
//   XRV1_RETIRE_PERF_EN  when defined, perf_retired_o accumulates retire_cnt_o
//                        (mod 2^32); otherwise it is tied to 0.
module xrv1_retire_ctrl #(
  parameter int ITAG_WIDTH_P = 3,
  parameter int NUM_WB_P     = 2,
  parameter int MAX_RETIRE_P = 2,
  localparam int iqueue_size_lp = 1 << ITAG_WIDTH_P
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   issue_vld_i,
  input  logic [ITAG_WIDTH_P-1:0]                issue_itag_i,
  input  logic [NUM_WB_P-1:0]                    wb_vld_i,
  input  logic [NUM_WB_P-1:0][ITAG_WIDTH_P-1:0]  wb_itag_i,
  input  logic [iqueue_size_lp-1:0]              iqueue_vld_i,
  input  logic [ITAG_WIDTH_P-1:0]                retire_itag_i,
  input  logic                                   drain_req_i,
  output logic [ITAG_WIDTH_P-1:0]                retire_cnt_o,
  output logic                                   issue_hold_o,
  output logic                                   drained_o,
  output logic                                   wb_err_o,
  output logic [31:0]                            perf_retired_o
);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

  state_e                      state_q, state_d;
  logic [iqueue_size_lp-1:0]   done_q, done_d;
  logic                        wb_err_q, wb_err_d;
  logic [ITAG_WIDTH_P-1:0]     cnt;
  logic [iqueue_size_lp-1:0]   ret_mask;
  logic [ITAG_WIDTH_P-1:0]     idx;
  logic                        run;

  // Head scan: depends only on done_q and iqueue state, so no wb/issue
  // input reaches retire_cnt_o combinationally. Itag arithmetic wraps
  // naturally at ITAG_WIDTH_P bits.
  always_comb begin
    cnt      = '0;
    ret_mask = '0;
    run      = 1'b1;
    idx      = '0;
    for (int i = 0; i < MAX_RETIRE_P; i++) begin
      idx = retire_itag_i + ITAG_WIDTH_P'(i);
      if (run && iqueue_vld_i[idx] && done_q[idx]) begin
        cnt           = cnt + ITAG_WIDTH_P'(1);
        ret_mask[idx] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  assign retire_cnt_o = cnt;

  // Done-bit update: retire clears first, then completions set, and an
  // issue clear is applied last so it wins over anything else.
  always_comb begin
    done_d   = done_q & ~ret_mask;
    wb_err_d = wb_err_q;
    for (int p = 0; p < NUM_WB_P; p++) begin
      if (wb_vld_i[p]) begin
        if (iqueue_vld_i[wb_itag_i[p]]) done_d[wb_itag_i[p]] = 1'b1;
        else                            wb_err_d             = 1'b1;
      end
    end
    if (issue_vld_i) done_d[issue_itag_i] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (drain_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req_i)
          state_d = RUN;
        else if ((iqueue_vld_i == '0) && (cnt == '0) && !issue_vld_i)
          state_d = IDLE;
      end
      IDLE:  if (!drain_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      done_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign issue_hold_o = (state_q != RUN);
  assign drained_o    = (state_q == IDLE);
  assign wb_err_o     = wb_err_q;

`ifdef XRV1_RETIRE_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_q + 32'(cnt);
  end
  assign perf_retired_o = perf_q;
`else
  assign perf_retired_o = '0;
`endif

endmodule

// File: tb/tb_xrv1_retire_ctrl.sv
// Directed bench for xrv1_retire_ctrl. A small behavioural iqueue (valid
// vector + head pointer) closes the loop around the DUT; all expected values
// are hand-computed constants.
module tb_xrv1_retire_ctrl;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_vld = 1'b0;
  logic [2:0]      issue_itag = '0;
  logic [1:0]      wb_vld = '0;
  logic [1:0][2:0] wb_itag = '0;
  logic [7:0]      qv;
  logic [2:0]      head;
  logic            drain_req = 1'b0;
  logic [2:0]      retire_cnt;
  logic            issue_hold, drained, wb_err;
  logic [31:0]     perf;
  logic [2:0]      tail;
  int              checks = 0;
  int              failures = 0;

  always #5 clk = ~clk;

  xrv1_retire_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_vld_i(issue_vld), .issue_itag_i(issue_itag),
    .wb_vld_i(wb_vld), .wb_itag_i(wb_itag),
    .iqueue_vld_i(qv), .retire_itag_i(head),
    .drain_req_i(drain_req),
    .retire_cnt_o(retire_cnt), .issue_hold_o(issue_hold),
    .drained_o(drained), .wb_err_o(wb_err), .perf_retired_o(perf)
  );

  function automatic logic [7:0] qnext(logic [7:0] v, logic [2:0] h, logic [2:0] n,
                                       logic iv, logic [2:0] it);
    for (int i = 0; i < 8; i++)
      if (i < int'(n)) v[h + 3'(i)] = 1'b0;
    if (iv) v[it] = 1'b1;
    return v;
  endfunction

  // Behavioural iqueue: allocate at issue, drop retire_cnt entries at head.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qv   <= '0;
      head <= '0;
    end else begin
      qv   <= qnext(qv, head, retire_cnt, issue_vld, issue_itag);
      head <= head + retire_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t);
    issue_vld = 1'b1; issue_itag = t; cyc(); issue_vld = 1'b0;
  endtask

  task automatic wb2(input logic [1:0] v, input logic [2:0] a, input logic [2:0] b);
    wb_vld = v; wb_itag[0] = a; wb_itag[1] = b; cyc(); wb_vld = '0;
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] exp);
`ifdef XRV1_RETIRE_PERF_EN
    chk(tag, perf, exp);
`else
    chk(tag, perf, 32'd0);
`endif
  endtask

  initial begin
    tail = '0;
    // Reset state
    #3;
    chk("rst_cnt", 32'(retire_cnt), 0);
    chk("rst_hold", 32'(issue_hold), 0);
    chk("rst_drained", 32'(drained), 0);
    chk("rst_err", 32'(wb_err), 0);
    chk("rst_perf", perf, 0);
    #19 rst_n = 1'b1;
    cyc();

    // Out-of-order completion: issue 0,1,2; wb 2,0,1
    issue(0); issue(1); issue(2);
    chk("ooo_issued", 32'(retire_cnt), 0);
    wb2(2'b01, 3'd2, 3'd0);
    chk("ooo_wb2", 32'(retire_cnt), 0);
    wb2(2'b01, 3'd0, 3'd0);
    chk("ooo_wb0", 32'(retire_cnt), 1);
    wb2(2'b01, 3'd1, 3'd0);
    chk("ooo_wb1", 32'(retire_cnt), 2);
    cyc();
    chk("ooo_empty", 32'(retire_cnt), 0);
    chk_perf("ooo_perf", 3);

    // Fill all 8 entries starting at head 3, complete in pairs (wraps 7->0)
    for (int i = 0; i < 8; i++) issue(3'(3 + i));
    chk("full_qv", 32'(qv), 32'hff);
    chk("full_cnt0", 32'(retire_cnt), 0);
    wb2(2'b11, 3'd3, 3'd4);
    chk("burst1", 32'(retire_cnt), 2);
    wb2(2'b11, 3'd5, 3'd6);
    chk("burst2", 32'(retire_cnt), 2);
    wb2(2'b11, 3'd7, 3'd0);
    chk("burst3_wrap", 32'(retire_cnt), 2);
    chk("burst3_head", 32'(head), 7);
    wb2(2'b11, 3'd1, 3'd2);
    chk("burst4", 32'(retire_cnt), 2);
    cyc();
    chk("burst_qv_empty", 32'(qv), 0);
    chk("burst_cnt_end", 32'(retire_cnt), 0);
    chk_perf("burst_perf", 11);

    // Both ports name itag 3 at head
    issue(3);
    wb2(2'b11, 3'd3, 3'd3);
    chk("dup_cnt", 32'(retire_cnt), 1);
    chk("dup_err", 32'(wb_err), 0);
    cyc();
    chk("dup_done", 32'(retire_cnt), 0);

    // Completion to an invalid entry
    wb2(2'b01, 3'd5, 3'd0);
    chk("err_set", 32'(wb_err), 1);
    chk("err_cnt", 32'(retire_cnt), 0);
    cyc(); cyc();
    chk("err_sticky", 32'(wb_err), 1);

    // Drain with 3 outstanding; issue of 6 coincides with drain rising
    issue(4); issue(5);
    drain_req = 1'b1;
    issue(6);
    chk("drn_hold", 32'(issue_hold), 1);
    chk("drn_not_drained", 32'(drained), 0);
    wb2(2'b11, 3'd5, 3'd6);
    chk("drn_head_wait", 32'(retire_cnt), 0);
    wb2(2'b01, 3'd4, 3'd0);
    chk("drn_cap", 32'(retire_cnt), 2);
    cyc();
    chk("drn_last", 32'(retire_cnt), 1);
    chk("drn_busy", 32'(drained), 0);
    cyc();
    chk("drn_still", 32'(drained), 0);
    cyc();
    chk("drn_idle", 32'(drained), 1);
    chk("drn_idle_hold", 32'(issue_hold), 1);
    drain_req = 1'b0;
    cyc();
    chk("drn_run_hold", 32'(issue_hold), 0);
    chk("drn_run_drained", 32'(drained), 0);
    chk_perf("drn_perf", 15);

    // Drain aborted before the queue empties
    drain_req = 1'b1;
    issue(7);
    chk("abort_hold", 32'(issue_hold), 1);
    drain_req = 1'b0;
    cyc();
    chk("abort_run", 32'(issue_hold), 0);
    wb2(2'b01, 3'd7, 3'd0);
    chk("abort_ret", 32'(retire_cnt), 1);
    cyc();

    // Asynchronous reset mid-burst
    issue(0); issue(1);
    drain_req = 1'b1;
    wb2(2'b11, 3'd0, 3'd1);
    chk("mid_cnt", 32'(retire_cnt), 2);
    chk("mid_hold", 32'(issue_hold), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(retire_cnt), 0);
    chk("arst_hold", 32'(issue_hold), 0);
    chk("arst_err", 32'(wb_err), 0);
    chk("arst_perf", perf, 0);
    drain_req = 1'b0;
    #7 rst_n = 1'b1;
    cyc();
    chk("post_cnt", 32'(retire_cnt), 0);
    issue(0);
    chk("post_issue", 32'(retire_cnt), 0);
    wb2(2'b01, 3'd0, 3'd0);
    chk("post_wb", 32'(retire_cnt), 1);
    chk("post_err", 32'(wb_err), 0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xrv1_retire_ctrl.md
# xrv1_retire_ctrl

In-order retirement controller for the xrv1 micro-core instruction queue. It tracks per-itag completion reported by the writeback ports and computes how many head-of-queue entries retire each cycle, capped per cycle; that count drives the iqueue's retire count input. It also sequences pipeline drain: it holds issue until the queue empties, then reports drained. It sits between the functional-unit writeback buses and the iqueue.

## Interface
- ITAG_WIDTH_P, 3, itag width; must match the iqueue.
- iqueue_size_lp, 1<<ITAG_WIDTH_P, queue depth (derived).
- NUM_WB_P, 2, number of writeback/completion ports.
- MAX_RETIRE_P, 2, max retirements per cycle; legal range 1..iqueue_size_lp-1.

- clk_i  in  1  clock; all state on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_vld_i  in  1  entry allocated this cycle (same qualifier as the iqueue's issue_vld_i).
- issue_itag_i  in  ITAG_WIDTH_P  itag being allocated.
- wb_vld_i  in  NUM_WB_P  completion valid per port.
- wb_itag_i  in  NUM_WB_P x ITAG_WIDTH_P  completing itag per port.
- iqueue_vld_i  in  iqueue_size_lp  iqueue entry valid vector.
- retire_itag_i  in  ITAG_WIDTH_P  iqueue head pointer.
- drain_req_i  in  1  level request to drain the pipeline.
- retire_cnt_o  out  ITAG_WIDTH_P  entries to retire this cycle.
- issue_hold_o  out  1  block new issue.
- drained_o  out  1  queue empty and issue held.
- wb_err_o  out  1  sticky: completion to an invalid entry.
- perf_retired_o  out  32  retired-instruction counter (see Configuration).

## Operation
- done_q[iqueue_size_lp]: completion bit per itag.
- On issue_vld_i, done_q[issue_itag_i] is cleared.
- On wb_vld_i[p] with iqueue_vld_i[wb_itag_i[p]]=1, done_q[wb_itag_i[p]] is set. Two ports naming the same itag in one cycle set the bit once; this is not an error.
- If wb_vld_i[p] names an entry with iqueue_vld_i=0, the write is ignored and wb_err_o is set. wb_err_o clears only on reset.
- retire_cnt_o: the number of consecutive entries k, starting at retire_itag_i and wrapping modulo iqueue_size_lp, with iqueue_vld_i[k] & done_q[k], capped at MAX_RETIRE_P. The scan stops at the first entry that is not done or not valid.
- Retired entries have their done_q bits cleared on the same edge.
- Wrap-around: the scan starting at itag iqueue_size_lp-1 continues at itag 0.
- Empty queue: retire_cnt_o = 0.
- Full queue with all entries done: retire_cnt_o = MAX_RETIRE_P.
- FSM states: RUN, DRAIN, IDLE. Reset state is RUN.
  - RUN -> DRAIN when drain_req_i=1.
  - DRAIN -> IDLE when iqueue_vld_i==0, retire_cnt_o==0 and issue_vld_i==0.
  - IDLE -> RUN when drain_req_i=0.
  - DRAIN -> RUN if drain_req_i drops before the queue is empty.
- issue_hold_o = (state != RUN). drained_o = (state == IDLE).
- Retirement continues normally in DRAIN and IDLE.

## Timing
- Reset values: done_q=0, state=RUN, retire_cnt_o=0 (queue empty), issue_hold_o=0, drained_o=0, wb_err_o=0, perf_retired_o=0.
- Reset asserted mid-operation clears all state immediately; the iqueue must be reset in the same window.
- retire_cnt_o is combinational from done_q, iqueue_vld_i and retire_itag_i only. There is no combinational path from wb_* or issue_* to retire_cnt_o.
- Completion latency: writeback in cycle N sets the done bit at edge N; earliest retire_cnt_o contribution is cycle N+1.
- issue_hold_o and drained_o are decoded from the registered state and change one cycle after the triggering input is sampled.
- An issue accepted in the same cycle drain_req_i first rises is legal and is drained.
- Issue and retire on the same itag in one cycle is impossible while the iqueue is not full. An issue clear takes priority over a retire clear; both clear the bit.

## Configuration
- XRV1_RETIRE_PERF_EN defined: perf_retired_o is a 32-bit register that adds retire_cnt_o every cycle, wraps modulo 2^32, and resets to 0.
- XRV1_RETIRE_PERF_EN undefined: perf_retired_o is tied to 0 and no counter logic is instantiated.

## Test plan
- Reset, issue itags 0,1,2, then writeback order 2,0,1 one per cycle -> retire_cnt_o stays 0, then 1 (itag 0), then 2 (itags 1,2). With the macro defined, perf_retired_o ends at 3.
- Fill 8 entries, complete all in one burst over 4 cycles on 2 ports -> retire_cnt_o is 2 per cycle for 4 cycles, scan wraps from itag 7 to itag 0 correctly, and iqueue_vld_i ends at 0.
- Writeback to itag 5 while iqueue_vld_i[5]=0 -> done_q unchanged, wb_err_o=1 next cycle and held until reset.
- Raise drain_req_i with 3 entries outstanding -> issue_hold_o=1 the next cycle; drained_o=1 only after the last retirement; dropping drain_req_i -> RUN with issue_hold_o=0 one cycle later.
- Both wb ports name itag 3 in the same cycle, itag 3 at the head -> retire_cnt_o=1 next cycle, wb_err_o stays 0.
- Assert rst_ni low mid-burst with done bits set -> all outputs return to reset values asynchronously; after release, retire_cnt_o=0 until a new issue and writeback occur.
